// File: rtl/rvfi_gen_pkg.sv
// Shared types for the RVFI retirement generator: record payload and order width.
package rvfi_gen_pkg;

   localparam int unsigned REC_XLEN = 64;
   localparam int unsigned ORDER_W  = 64;
   localparam int unsigned INSN_W   = 32;

   typedef struct packed {
      logic [REC_XLEN-1:0] pc;
      logic [REC_XLEN-1:0] next_pc;
      logic [INSN_W-1:0]   insn;
      logic                trap;
   } rvfi_rec_t;

endpackage

// File: rtl/rvfi_retire_gen_if.sv
// Commit-stage record handshake plus the RVFI retirement channels.
interface rvfi_retire_gen_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NRET = 1
);
   logic                 in_valid;
   logic                 in_ready;
   logic [XLEN-1:0]      in_pc;
   logic [XLEN-1:0]      in_next_pc;
   logic [31:0]          in_insn;
   logic                 in_trap;
   logic                 retire_en;
   logic [NRET-1:0]      rvfi_valid;
   logic [64*NRET-1:0]   rvfi_order;
   logic [32*NRET-1:0]   rvfi_insn;
   logic [NRET-1:0]      rvfi_trap;
   logic [NRET-1:0]      rvfi_intr;
   logic [XLEN*NRET-1:0] rvfi_pc_rdata;
   logic [XLEN*NRET-1:0] rvfi_pc_wdata;

   modport master (
      output in_valid, in_pc, in_next_pc, in_insn, in_trap, retire_en,
      input  in_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
             rvfi_pc_rdata, rvfi_pc_wdata
   );

   modport slave (
      input  in_valid, in_pc, in_next_pc, in_insn, in_trap, retire_en,
      output in_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
             rvfi_pc_rdata, rvfi_pc_wdata
   );
endinterface

// File: rtl/rvfi_gen_fifo.sv
// Circular record buffer: one push per cycle, up to NRET pops, NRET head entries visible.
module rvfi_gen_fifo
   import rvfi_gen_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned NRET  = 1,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned PW    = $clog2(DEPTH) + 1
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            push,
   input  rvfi_rec_t       push_rec,
   input  logic [PW-1:0]   pop_cnt,
   output logic [PW-1:0]   count,
   output rvfi_rec_t       head_rec [NRET]
);

   rvfi_rec_t     mem_q [DEPTH];
   rvfi_rec_t     mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] count_q, count_d;

   // Caller guarantees push only when not full and pop_cnt <= count.
   always_comb begin
      mem_d   = mem_q;
      tail_d  = tail_q;
      head_d  = head_q + pop_cnt;
      count_d = count_q + PW'(push) - pop_cnt;
      if (push) begin
         mem_d[tail_q[AW-1:0]] = push_rec;
         tail_d                = tail_q + PW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   always_comb begin
      for (int unsigned i = 0; i < NRET; i++) begin
         head_rec[i] = mem_q[AW'(head_q + PW'(i))];
      end
   end

   assign count = count_q;

endmodule

// File: rtl/rvfi_retire_gen.sv
// RVFI transmitter: buffers commit records, assigns order numbers, flags PC discontinuities.
module rvfi_retire_gen
   import rvfi_gen_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NRET  = 1,
   parameter int unsigned DEPTH = 4
) (
   input logic               clock,
   input logic               resetn,
   rvfi_retire_gen_if.slave  bus
);

   localparam int unsigned PW = $clog2(DEPTH) + 1;

   rvfi_rec_t     push_rec;
   rvfi_rec_t     head_rec [NRET];
   logic [PW-1:0] count;
   logic [PW-1:0] pop_cnt;
   logic          push;

   logic [ORDER_W-1:0]      order_cnt_q, order_cnt_d;
   logic [XLEN-1:0]         last_npc_q, last_npc_d;
   logic                    have_last_q, have_last_d;
   logic [NRET-1:0]         valid_q, valid_d;
   logic [ORDER_W*NRET-1:0] order_q, order_d;
   logic [INSN_W*NRET-1:0]  insn_q, insn_d;
   logic [NRET-1:0]         trap_q, trap_d;
   logic [NRET-1:0]         intr_q, intr_d;
   logic [XLEN*NRET-1:0]    pc_rdata_q, pc_rdata_d;
   logic [XLEN*NRET-1:0]    pc_wdata_q, pc_wdata_d;

   assign bus.in_ready = (count < PW'(DEPTH));
   assign push         = bus.in_valid && bus.in_ready;

   always_comb begin
      push_rec         = '0;
      push_rec.pc      = REC_XLEN'(bus.in_pc);
      push_rec.next_pc = REC_XLEN'(bus.in_next_pc);
      push_rec.insn    = bus.in_insn;
      push_rec.trap    = bus.in_trap;
   end

   always_comb begin
      pop_cnt = '0;
      if (bus.retire_en) begin
         pop_cnt = (count < PW'(NRET)) ? count : PW'(NRET);
      end
   end

   rvfi_gen_fifo #(
      .DEPTH (DEPTH),
      .NRET  (NRET)
   ) u_fifo (
      .clock    (clock),
      .resetn   (resetn),
      .push     (push),
      .push_rec (push_rec),
      .pop_cnt  (pop_cnt),
      .count    (count),
      .head_rec (head_rec)
   );

   // Each retiring channel is compared against its predecessor's next_pc; the running
   // last_npc_d/have_last_d carry that predecessor across channels and into the register.
   always_comb begin
      valid_d     = '0;
      order_d     = '0;
      insn_d      = '0;
      trap_d      = '0;
      intr_d      = '0;
      pc_rdata_d  = '0;
      pc_wdata_d  = '0;
      last_npc_d  = last_npc_q;
      have_last_d = have_last_q;
      order_cnt_d = order_cnt_q + ORDER_W'(pop_cnt);
      for (int unsigned i = 0; i < NRET; i++) begin
         if (PW'(i) < pop_cnt) begin
            valid_d[i]                      = 1'b1;
            order_d[i*ORDER_W +: ORDER_W]   = order_cnt_q + ORDER_W'(i);
            insn_d[i*INSN_W +: INSN_W]      = head_rec[i].insn;
            trap_d[i]                       = head_rec[i].trap;
            pc_rdata_d[i*XLEN +: XLEN]      = XLEN'(head_rec[i].pc);
            pc_wdata_d[i*XLEN +: XLEN]      = XLEN'(head_rec[i].next_pc);
            intr_d[i]   = have_last_d && (XLEN'(head_rec[i].pc) != last_npc_d);
            last_npc_d  = XLEN'(head_rec[i].next_pc);
            have_last_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         order_cnt_q <= '0;
         last_npc_q  <= '0;
         have_last_q <= 1'b0;
         valid_q     <= '0;
         order_q     <= '0;
         insn_q      <= '0;
         trap_q      <= '0;
         intr_q      <= '0;
         pc_rdata_q  <= '0;
         pc_wdata_q  <= '0;
      end else begin
         order_cnt_q <= order_cnt_d;
         last_npc_q  <= last_npc_d;
         have_last_q <= have_last_d;
         valid_q     <= valid_d;
         order_q     <= order_d;
         insn_q      <= insn_d;
         trap_q      <= trap_d;
         intr_q      <= intr_d;
         pc_rdata_q  <= pc_rdata_d;
         pc_wdata_q  <= pc_wdata_d;
      end
   end

   assign bus.rvfi_valid    = valid_q;
   assign bus.rvfi_order    = order_q;
   assign bus.rvfi_insn     = insn_q;
   assign bus.rvfi_trap     = trap_q;
   assign bus.rvfi_intr     = intr_q;
   assign bus.rvfi_pc_rdata = pc_rdata_q;
   assign bus.rvfi_pc_wdata = pc_wdata_q;

endmodule

// File: tb/tb_rvfi_retire_gen.sv
// Scoreboard bench for rvfi_retire_gen: a queue-based retirement model predicts every packet.
module tb_rvfi_retire_gen;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NRET  = 2;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] npc;
      logic [31:0]     insn;
      logic            trap;
   } rec_t;

   typedef struct {
      logic [63:0] order;
      rec_t        r;
      logic        intr;
      int          cyc;
   } exp_t;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   rvfi_retire_gen_if #(.XLEN(XLEN), .NRET(NRET)) bus ();

   rvfi_retire_gen #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   rec_t            mq [$];
   exp_t            sb [$];
   logic [63:0]     m_order = '0;
   logic [XLEN-1:0] m_last  = '0;
   logic            m_have  = 1'b0;
   int              model_count = 0;
   int              cyc = 0;
   bit              chk_en = 1'b0;
   int              n_checks = 0;
   int              n_fail = 0;

   logic [63:0]     seen_order [$];
   logic            seen_intr  [$];
   logic [XLEN-1:0] seen_pc    [$];
   int              seen_cyc   [$];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model: records retire oldest first, one order number each, NRET per cycle at most.
   always @(posedge clock) begin
      bit   do_push;
      int   k;
      exp_t e;
      rec_t nr;
      cyc++;
      if (!resetn) begin
         mq.delete();
         m_order = '0;
         m_have  = 1'b0;
      end else begin
         do_push = bus.in_valid && (mq.size() < DEPTH);
         k = 0;
         if (bus.retire_en) k = (mq.size() < NRET) ? mq.size() : NRET;
         for (int i = 0; i < k; i++) begin
            e.r     = mq.pop_front();
            e.order = m_order;
            m_order = m_order + 64'd1;
            e.intr  = m_have && (e.r.pc != m_last);
            m_last  = e.r.npc;
            m_have  = 1'b1;
            e.cyc   = cyc;
            sb.push_back(e);
         end
         if (do_push) begin
            nr.pc   = bus.in_pc;
            nr.npc  = bus.in_next_pc;
            nr.insn = bus.in_insn;
            nr.trap = bus.in_trap;
            mq.push_back(nr);
         end
      end
      model_count = mq.size();
   end

   // Monitor: every valid channel must match the next expected retirement, in the same cycle.
   always @(negedge clock) begin
      exp_t e;
      if (chk_en) begin
         chk("in_ready", 64'(bus.in_ready), 64'(model_count < DEPTH));
         for (int i = 0; i < NRET; i++) begin
            if (bus.rvfi_valid[i]) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected packet ch%0d: order %h, none expected (cycle %0d)",
                           i, bus.rvfi_order[i*64 +: 64], cyc);
               end else begin
                  e = sb.pop_front();
                  chk("order", bus.rvfi_order[i*64 +: 64], e.order);
                  chk("pc_rdata", 64'(bus.rvfi_pc_rdata[i*XLEN +: XLEN]), 64'(e.r.pc));
                  chk("pc_wdata", 64'(bus.rvfi_pc_wdata[i*XLEN +: XLEN]), 64'(e.r.npc));
                  chk("insn", 64'(bus.rvfi_insn[i*32 +: 32]), 64'(e.r.insn));
                  chk("trap", 64'(bus.rvfi_trap[i]), 64'(e.r.trap));
                  chk("intr", 64'(bus.rvfi_intr[i]), 64'(e.intr));
                  chk("cycle", 64'(cyc), 64'(e.cyc));
                  seen_order.push_back(bus.rvfi_order[i*64 +: 64]);
                  seen_intr.push_back(bus.rvfi_intr[i]);
                  seen_pc.push_back(bus.rvfi_pc_rdata[i*XLEN +: XLEN]);
                  seen_cyc.push_back(cyc);
               end
            end else begin
               chk("idle channel zero",
                   64'(|{bus.rvfi_order[i*64 +: 64], bus.rvfi_insn[i*32 +: 32], bus.rvfi_trap[i],
                         bus.rvfi_intr[i], bus.rvfi_pc_rdata[i*XLEN +: XLEN],
                         bus.rvfi_pc_wdata[i*XLEN +: XLEN]}), 64'd0);
            end
         end
         while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing packet: order %h not emitted by cycle %0d", e.order, cyc);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push_rec(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc,
                           input logic [31:0] insn, input logic trap);
      bit ok = 1'b0;
      bit r;
      bus.in_valid   = 1'b1;
      bus.in_pc      = pc;
      bus.in_next_pc = npc;
      bus.in_insn    = insn;
      bus.in_trap    = trap;
      for (int n = 0; n < 200; n++) begin
         r = bus.in_ready;
         @(negedge clock);
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("push accept timeout", 64'(ok), 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.retire_en = 1'b1;
      for (int n = 0; n < 100; n++) begin
         if (model_count == 0 && sb.size() == 0) break;
         @(negedge clock);
      end
      chk("drain timeout", 64'(model_count + sb.size()), 64'd0);
      idle(1);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      idle(2);
      resetn = 1'b1;
   endtask

   function automatic void clear_logs();
      seen_order.delete();
      seen_intr.delete();
      seen_pc.delete();
      seen_cyc.delete();
   endfunction

   task automatic check_log(input string t, input int idx, input logic [63:0] ord, input logic intr);
      if (idx < seen_order.size()) begin
         chk({t, " order"}, seen_order[idx], ord);
         chk({t, " intr"}, 64'(seen_intr[idx]), 64'(intr));
      end else begin
         chk({t, " log size"}, 64'(seen_order.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [XLEN-1:0] cur;
      logic [XLEN-1:0] nx;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_next_pc = '0;
      bus.in_insn = '0; bus.in_trap = 1'b0; bus.retire_en = 1'b0;
      resetn = 1'b0;
      idle(3);
      resetn = 1'b1;
      chk_en = 1'b1;
      chk("reset rvfi_valid", 64'(bus.rvfi_valid), 64'd0);
      chk("reset in_ready", 64'(bus.in_ready), 64'd1);

      // Three sequential records, one per cycle.
      clear_logs();
      bus.retire_en = 1'b1;
      push_rec(32'h0, 32'h4, $urandom, 1'b0);
      push_rec(32'h4, 32'h8, $urandom, 1'b0);
      push_rec(32'h8, 32'hc, $urandom, 1'b1);
      drain();
      for (int i = 0; i < 3; i++) check_log("seq", i, 64'(i), 1'b0);
      if (seen_cyc.size() == 3) chk("seq back-to-back", 64'(seen_cyc[2] - seen_cyc[0]), 64'd2);

      // Four queued records retire two per cycle.
      clear_logs();
      bus.retire_en = 1'b0;
      for (int i = 0; i < 4; i++) push_rec(XLEN'(32'hc + 4*i), XLEN'(32'h10 + 4*i), $urandom, 1'b0);
      drain();
      for (int i = 0; i < 4; i++) check_log("dual", i, 64'(3 + i), 1'b0);
      if (seen_cyc.size() == 4) begin
         chk("dual pair A", 64'(seen_cyc[1]), 64'(seen_cyc[0]));
         chk("dual pair B", 64'(seen_cyc[3]), 64'(seen_cyc[2]));
         chk("dual B after A", 64'(seen_cyc[2]), 64'(seen_cyc[0] + 1));
      end

      // PC discontinuity after a fresh reset.
      do_reset();
      clear_logs();
      bus.retire_en = 1'b1;
      push_rec(32'h10, 32'h14, $urandom, 1'b0);
      push_rec(32'h100, 32'h104, $urandom, 1'b0);
      push_rec(32'h104, 32'h108, $urandom, 1'b0);
      drain();
      check_log("intr0", 0, 64'd0, 1'b0);
      check_log("intr1", 1, 64'd1, 1'b1);
      check_log("intr2", 2, 64'd2, 1'b0);

      // Fill the buffer with retirement stalled, then release.
      clear_logs();
      bus.retire_en = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++)
               push_rec(XLEN'(32'h300 + 4*i), XLEN'(32'h304 + 4*i), $urandom, 1'b0);
         end
         begin
            idle(6);
            chk("full in_ready", 64'(bus.in_ready), 64'd0);
            bus.retire_en = 1'b1;
         end
      join
      drain();
      chk("full count", 64'(seen_pc.size()), 64'd5);
      for (int i = 0; i < 5 && i < seen_pc.size(); i++)
         chk("full push order", 64'(seen_pc[i]), 64'(32'h300 + 4*i));

      // Order counter wrap.
      clear_logs();
      bus.retire_en = 1'b0;
      force dut.order_cnt_d = 64'hFFFF_FFFF_FFFF_FFFF;
      m_order = 64'hFFFF_FFFF_FFFF_FFFF;
      idle(1);
      release dut.order_cnt_d;
      push_rec(32'h400, 32'h404, $urandom, 1'b0);
      push_rec(32'h404, 32'h408, $urandom, 1'b0);
      drain();
      check_log("wrap0", 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      check_log("wrap1", 1, 64'd0, 1'b0);
      if (seen_cyc.size() == 2) chk("wrap same cycle", 64'(seen_cyc[1]), 64'(seen_cyc[0]));

      // Reset with buffered records and a pop about to happen.
      bus.retire_en = 1'b0;
      for (int i = 0; i < 3; i++) push_rec(XLEN'(32'h500 + 4*i), XLEN'(32'h504 + 4*i), $urandom, 1'b0);
      clear_logs();
      bus.retire_en = 1'b1;
      resetn = 1'b0;
      idle(1);
      chk("rst valid", 64'(bus.rvfi_valid), 64'd0);
      chk("rst order", 64'(|bus.rvfi_order), 64'd0);
      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      resetn = 1'b1;
      push_rec(32'h200, 32'h204, $urandom, 1'b0);
      drain();
      chk("rst discarded", 64'(seen_order.size()), 64'd1);
      check_log("post-rst", 0, 64'd0, 1'b0);

      // Random traffic with stalls and occasional jumps.
      cur = 32'h1000;
      for (int c = 0; c < 400; c++) begin
         bus.retire_en  = ($urandom % 4) != 0;
         bus.in_valid   = ($urandom % 3) != 0;
         nx = (($urandom % 6) == 0) ? XLEN'($urandom & 32'hFFFF_FFFC) : cur + 32'd4;
         bus.in_pc      = cur;
         bus.in_next_pc = nx;
         bus.in_insn    = $urandom;
         bus.in_trap    = 1'($urandom % 2);
         cur = nx;
         idle(1);
      end
      drain();
      chk("scoreboard empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rvfi_retire_gen.md
# rvfi_retire_gen

RVFI transmitter: accepts retirement records from a core's commit stage over a valid/ready handshake, buffers them, and drives the RVFI retirement channels (`rvfi_valid`, `rvfi_order`, `rvfi_insn`, `rvfi_trap`, `rvfi_intr`, `rvfi_pc_rdata`, `rvfi_pc_wdata`). It is the producing end of the interface consumed by the formal checks, including PC-continuity and ordering checks. Order numbers are assigned here, and `rvfi_intr` is derived from PC discontinuity.

## Interface
- `XLEN`, 32: register/PC width (32 or 64).
- `NRET`, 1: retirement channels per cycle (1..4).
- `DEPTH`, 4: record buffer entries (power of two, ≥ NRET).

- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  record offered.
- `in_ready`  out  1  buffer can accept; equals `count < DEPTH`.
- `in_pc`  in  XLEN  PC of retiring instruction.
- `in_next_pc`  in  XLEN  PC of next instruction.
- `in_insn`  in  32  instruction word.
- `in_trap`  in  1  instruction trapped.
- `retire_en`  in  1  retirement permitted this cycle; low models a retire stall.
- `rvfi_valid`  out  NRET  per-channel valid.
- `rvfi_order`  out  64*NRET  per-channel order.
- `rvfi_insn`  out  32*NRET
- `rvfi_trap`  out  NRET
- `rvfi_intr`  out  NRET  first instruction after a PC discontinuity.
- `rvfi_pc_rdata`  out  XLEN*NRET  `in_pc` of the record.
- `rvfi_pc_wdata`  out  XLEN*NRET  `in_next_pc` of the record.

## Operation
- Push: `in_valid && in_ready` at an edge writes one record into the FIFO tail. There is no bypass.
- `in_ready` depends on the registered `count` only. It never depends on a same-cycle pop.
- Pop: at each edge with `retire_en=1`, k = min(count, NRET) records leave the head, oldest first.
  - The record popped i-th goes to channel i, with `rvfi_order[i] = order_cnt + i`.
  - `order_cnt` then advances by k.
  - Channels k..NRET-1 get `rvfi_valid=0`, with all other fields of those channels zeroed.
- With `retire_en=0` or `count=0`, all `rvfi_valid` are 0 at the next edge. `order_cnt` is unchanged.
- Push and pop at the same edge: `count_next = count + push - k`.
- Full: `in_ready=0`, and `in_valid` is ignored.
- `order_cnt` is 64 bits, starts at 0, and wraps modulo 2^64. Channel arithmetic wraps identically.
- Intr chain: register `last_npc`, with `have_last` cleared by reset.
  - Channel i: `intr = have_last_i && pc != last_npc_i`, where the predecessor is channel i-1 in the same cycle, else the registered `last_npc`.
  - After a non-empty pop, `last_npc` takes the `next_pc` of channel k-1, and `have_last` is set to 1.
  - The first instruction after reset has `intr=0`.
- Consequence: on consecutive orders n, n+1, `pc_rdata(n+1) == pc_wdata(n)` whenever `intr(n+1)=0`.

## Timing
- All RVFI outputs are registered. Each packet is valid for exactly one cycle.
- Latency: a record accepted at edge t, with an empty buffer and `retire_en=1`, is popped at edge t+1. It appears on the outputs in the cycle after edge t+1.
- Throughput: NRET records/cycle out, 1 record/cycle in.
- Reset (`resetn=0` at an edge) has the following effect at that edge, including mid-operation:
  - FIFO emptied, `count=0`, `order_cnt=0`, `have_last=0`.
  - All outputs 0.
  - `in_ready` reads 1 from the following cycle.
  - Records in flight are discarded, and no packet is emitted at that edge.

## Structure
- Package `rvfi_gen_pkg`:
  - `rvfi_rec_t` struct {pc, next_pc, insn, trap}, parameterised through `XLEN` via a localparam default of 64 with truncation at the ports.
  - `ORDER_W=64`.
- Sub-module `rvfi_gen_fifo`:
  - DEPTH-entry circular buffer with head/tail pointers of `log2(DEPTH)+1` bits and `count`.
  - Single push, multi-pop of up to NRET.
  - Exposes the NRET head entries combinationally.
- Top level: order counter, intr chain, output registers.

## Test plan
- Reset, then push three records (pc 0x0→0x4, 0x4→0x8, 0x8→0xc), `retire_en=1`, NRET=1 → orders 0,1,2 on consecutive cycles starting 2 cycles after the first push; `intr=0` on all three.
- NRET=2, four records queued, `retire_en` raised → cycle A: channels orders 0,1; cycle B: orders 2,3; `rvfi_valid=2'b11` both cycles.
- Push pc 0x10→0x14, then pc 0x100→0x104 → second packet has `intr=1`, order 1; a third record with pc 0x104 has `intr=0`.
- DEPTH=4, `retire_en=0`, push 5 → `in_ready` low after the 4th accept, 5th held; raise `retire_en` → 5th accepted the cycle after the first pop; all 5 emitted in push order.
- Preload `order_cnt` to 2^64-1 via force, NRET=2, two records → orders 0xFFFF_FFFF_FFFF_FFFF and 0.
- Assert `resetn=0` with 3 records buffered and a packet pending → next cycle all outputs 0; after release, a fresh record gets order 0 with `intr=0`.
